// File: rtl/small_ram_master.sv
// Burst initiator for a 64x8 synchronous single-port RAM: write stream, read stream and fill.
// Define SMALL_RAM_MASTER_VERIFY_EN to read back and check every fill range.
module small_ram_master #(
  parameter int AW = 6,
  parameter int DW = 8
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          Cmd_Valid,
  output logic          Cmd_Ready,
  input  logic [1:0]    Cmd_Op,
  input  logic [AW-1:0] Cmd_Addr,
  input  logic [AW-1:0] Cmd_Len,
  input  logic [DW-1:0] Cmd_Fill,
  input  logic [DW-1:0] Wr_Data,
  input  logic          Wr_Valid,
  output logic          Wr_Ready,
  output logic [DW-1:0] Rd_Data,
  output logic          Rd_Valid,
  output logic          Busy,
  output logic          Done,
  output logic          Verify_Err,
  output logic [AW-1:0] Mem_Address,
  output logic          Mem_WR,
  output logic          Mem_CS,
  output logic [DW-1:0] Mem_Di,
  input  logic [DW-1:0] Mem_Do
);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_READ, S_TAIL, S_FILL,
`ifdef SMALL_RAM_MASTER_VERIFY_EN
    S_VERIFY,
`endif
    S_DONE
  } state_t;

  state_t        st_q, st_d;
  logic [AW-1:0] cnt_q, rem_q;
  logic [DW-1:0] fill_q;
  logic          iss_q;
  logic          step, rd_issue, last;

  assign last        = (rem_q == '0);
  assign Mem_Address = cnt_q;
  assign Busy        = (st_q != S_IDLE);
  assign Done        = (st_q == S_DONE);

  always_comb begin
    st_d      = st_q;
    Cmd_Ready = 1'b0;
    Wr_Ready  = 1'b0;
    Mem_CS    = 1'b0;
    Mem_WR    = 1'b0;
    Mem_Di    = '0;
    step      = 1'b0;
    rd_issue  = 1'b0;
    case (st_q)
      S_IDLE: begin
        Cmd_Ready = 1'b1;
        if (Cmd_Valid) begin
          case (Cmd_Op)
            2'b00:   st_d = S_WRITE;
            2'b01:   st_d = S_READ;
            2'b10:   st_d = S_FILL;
            default: st_d = S_DONE;
          endcase
        end
      end
      S_WRITE: begin
        Wr_Ready = 1'b1;
        if (Wr_Valid) begin
          Mem_CS = 1'b1;
          Mem_WR = 1'b1;
          Mem_Di = Wr_Data;
          step   = 1'b1;
          if (last) st_d = S_DONE;
        end
      end
      S_FILL: begin
        Mem_CS = 1'b1;
        Mem_WR = 1'b1;
        Mem_Di = fill_q;
        step   = 1'b1;
`ifdef SMALL_RAM_MASTER_VERIFY_EN
        if (last) st_d = S_VERIFY;
`else
        if (last) st_d = S_DONE;
`endif
      end
`ifdef SMALL_RAM_MASTER_VERIFY_EN
      S_VERIFY,
`endif
      S_READ: begin
        Mem_CS   = 1'b1;
        step     = 1'b1;
        rd_issue = 1'b1;
        if (last) st_d = S_TAIL;
      end
      // Do is gated by CS, so CS stays up while the final word is captured
      S_TAIL: begin
        Mem_CS = 1'b1;
        st_d   = S_DONE;
      end
      S_DONE:  st_d = S_IDLE;
      default: st_d = S_IDLE;
    endcase
  end

`ifdef SMALL_RAM_MASTER_VERIFY_EN
  logic [AW-1:0] addr_q, len_q;
  logic          vrf_q, verr_q;

  assign Rd_Valid   = iss_q & ~vrf_q;
  assign Verify_Err = verr_q;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      addr_q <= '0;
      len_q  <= '0;
      vrf_q  <= 1'b0;
      verr_q <= 1'b0;
    end else begin
      vrf_q <= (st_q == S_VERIFY);
      if (Cmd_Valid && Cmd_Ready) begin
        addr_q <= Cmd_Addr;
        len_q  <= Cmd_Len;
        if (Cmd_Op == 2'b10) verr_q <= 1'b0;
      end else if (iss_q && vrf_q && (Mem_Do != fill_q)) begin
        verr_q <= 1'b1;
      end
    end
  end
`else
  assign Rd_Valid   = iss_q;
  assign Verify_Err = 1'b0;
`endif

  assign Rd_Data = Rd_Valid ? Mem_Do : '0;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      st_q   <= S_IDLE;
      cnt_q  <= '0;
      rem_q  <= '0;
      fill_q <= '0;
      iss_q  <= 1'b0;
    end else begin
      st_q  <= st_d;
      iss_q <= rd_issue;
      if (Cmd_Valid && Cmd_Ready) begin
        cnt_q  <= Cmd_Addr;
        rem_q  <= Cmd_Len;
        fill_q <= Cmd_Fill;
`ifdef SMALL_RAM_MASTER_VERIFY_EN
      end else if (st_q == S_FILL && last) begin
        cnt_q <= addr_q;
        rem_q <= len_q;
`endif
      end else if (step) begin
        // reads hold the last address through the tail cycle
        if (!(last && rd_issue)) cnt_q <= cnt_q + 1'b1;
        if (!last) rem_q <= rem_q - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_small_ram_master.sv
// Self-checking bench for small_ram_master with a behavioural 64x8 RAM and read scoreboard.
module tb_small_ram_master;
  logic       Clk = 0, Rst = 1;
  logic       Cmd_Valid = 0, Cmd_Ready;
  logic [1:0] Cmd_Op = 0;
  logic [5:0] Cmd_Addr = 0, Cmd_Len = 0;
  logic [7:0] Cmd_Fill = 0, Wr_Data = 0;
  logic       Wr_Valid = 0, Wr_Ready;
  logic [7:0] Rd_Data;
  logic       Rd_Valid, Busy, Done, Verify_Err;
  logic [5:0] Mem_Address;
  logic       Mem_WR, Mem_CS;
  logic [7:0] Mem_Di, Mem_Do;

  int checks = 0, errors = 0;
  int wr_cnt = 0, done_cnt = 0;
  logic [7:0] sb[$];
  logic [7:0] ram [64];
  logic [7:0] exp_mem [64];
  logic [7:0] do_q;
  logic       corrupt = 0;

  always #5 Clk = ~Clk;

  small_ram_master #(.AW(6), .DW(8)) dut (
    .Clk(Clk), .Rst(Rst), .Cmd_Valid(Cmd_Valid), .Cmd_Ready(Cmd_Ready), .Cmd_Op(Cmd_Op),
    .Cmd_Addr(Cmd_Addr), .Cmd_Len(Cmd_Len), .Cmd_Fill(Cmd_Fill), .Wr_Data(Wr_Data),
    .Wr_Valid(Wr_Valid), .Wr_Ready(Wr_Ready), .Rd_Data(Rd_Data), .Rd_Valid(Rd_Valid),
    .Busy(Busy), .Done(Done), .Verify_Err(Verify_Err), .Mem_Address(Mem_Address),
    .Mem_WR(Mem_WR), .Mem_CS(Mem_CS), .Mem_Di(Mem_Di), .Mem_Do(Mem_Do));

  always @(posedge Clk) if (Mem_CS) begin
    if (Mem_WR) ram[Mem_Address] <= Mem_Di;
    do_q <= ram[Mem_Address];
  end
  assign Mem_Do = corrupt ? 8'h00 : (Mem_CS ? do_q : 8'h00);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge Clk) begin
    chk("wr_without_cs", {31'd0, Mem_WR & ~Mem_CS}, 0);
    if (Mem_CS && Mem_WR) wr_cnt++;
    if (Done) done_cnt++;
    if (Rd_Valid) begin
      if (sb.size() == 0) chk("rd_extra", 1, 0);
      else chk("rd_data", {24'd0, Rd_Data}, {24'd0, sb.pop_front()});
    end
  end

  task automatic issue(input logic [1:0] op, input logic [5:0] a, input logic [5:0] l,
                       input logic [7:0] f);
    int n = 0;
    @(negedge Clk);
    while (!Cmd_Ready && n < 300) begin @(negedge Clk); n++; end
    if (!Cmd_Ready) chk("cmd_ready_timeout", 0, 1);
    Cmd_Valid = 1; Cmd_Op = op; Cmd_Addr = a; Cmd_Len = l; Cmd_Fill = f;
    @(posedge Clk); #1;
    Cmd_Valid = 0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    @(negedge Clk);
    while (!Done && n < 300) begin @(negedge Clk); n++; end
    chk(tag, {31'd0, Done}, 1);
  endtask

  task automatic write_burst(input logic [5:0] a, input logic [5:0] l, input logic [7:0] d [8],
                             input int gap_after, input int gap);
    logic [5:0] ad;
    issue(2'b00, a, l, 8'h00);
    for (int i = 0; i <= int'(l); i++) begin
      ad = a + 6'(i);
      Wr_Data = d[i]; Wr_Valid = 1; exp_mem[ad] = d[i];
      @(posedge Clk); #1;
      if (i == gap_after && gap > 0) begin
        Wr_Valid = 0;
        for (int g = 0; g < gap; g++) begin
          @(negedge Clk);
          chk("gap_cs_wr_busy", {29'd0, Mem_CS, Mem_WR, Busy}, 32'b001);
          @(posedge Clk); #1;
        end
      end
    end
    Wr_Valid = 0;
    @(negedge Clk);
    chk("wr_done_latency", {31'd0, Done}, 1);
  endtask

  task automatic read_burst(input logic [5:0] a, input logic [5:0] l);
    logic [5:0] ad;
    for (int i = 0; i <= int'(l); i++) begin ad = a + 6'(i); sb.push_back(exp_mem[ad]); end
    issue(2'b01, a, l, 8'h00);
    @(negedge Clk);
    chk("rd_first_issue", {24'd0, Rd_Valid, Mem_CS, Mem_Address}, {24'd0, 2'b01, a});
    for (int i = 0; i <= int'(l); i++) begin
      @(negedge Clk);
      chk("rd_valid_run", {31'd0, Rd_Valid}, 1);
    end
    @(negedge Clk);
    chk("rd_done_latency", {31'd0, Done}, 1);
    chk("rd_sb_empty", sb.size(), 0);
  endtask

  initial begin
    logic [7:0] dv [8];
    int w0, d0;
    for (int i = 0; i < 64; i++) exp_mem[i] = 8'h00;
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_outputs", {25'd0, Busy, Done, Mem_CS, Mem_WR, Rd_Valid, Verify_Err, Wr_Ready}, 0);
    Rst = 0;
    @(negedge Clk);
    chk("rst_ready", {31'd0, Cmd_Ready}, 1);
    chk("rst_addr_di_rd", {8'd0, 2'd0, Mem_Address, Mem_Di, Rd_Data}, 0);

    dv = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'h00, 8'h00, 8'h00, 8'h00};
    w0 = wr_cnt;
    write_burst(6'd5, 6'd3, dv, -1, 0);
    chk("wr_count_basic", wr_cnt - w0, 4);
    read_burst(6'd5, 6'd3);

    dv = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00};
    write_burst(6'd62, 6'd3, dv, -1, 0);
    chk("wrap_ram0", {24'd0, ram[0]}, 32'h33);
    chk("wrap_ram63", {24'd0, ram[63]}, 32'h22);
    read_burst(6'd62, 6'd3);

    dv = '{8'h31, 8'h32, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    w0 = wr_cnt;
    write_burst(6'd20, 6'd2, dv, 1, 3);
    chk("wr_count_gap", wr_cnt - w0, 3);
    read_burst(6'd20, 6'd2);

    issue(2'b10, 6'd0, 6'd63, 8'h5A);
    for (int i = 0; i < 64; i++) begin
      @(negedge Clk);
      chk("fill_cycle", {22'd0, Mem_CS, Mem_WR, Mem_Di}, {22'd0, 2'b11, 8'h5A});
    end
    for (int i = 0; i < 64; i++) exp_mem[i] = 8'h5A;
    wait_done("fill_done");
    chk("fill_no_err", {31'd0, Verify_Err}, 0);
    read_burst(6'd0, 6'd63);

`ifdef SMALL_RAM_MASTER_VERIFY_EN
    issue(2'b10, 6'd10, 6'd3, 8'h5A);
    repeat (6) @(posedge Clk);
    #1 corrupt = 1;
    @(posedge Clk); #1 corrupt = 0;
    wait_done("vrf_done");
    @(negedge Clk);
    chk("vrf_err_set", {31'd0, Verify_Err}, 1);
    issue(2'b10, 6'd10, 6'd3, 8'h5A);
    @(negedge Clk);
    chk("vrf_err_clear_on_accept", {31'd0, Verify_Err}, 0);
    wait_done("vrf_clean_done");
    chk("vrf_err_clean", {31'd0, Verify_Err}, 0);
`endif

    issue(2'b11, 6'd0, 6'd0, 8'h00);
    @(negedge Clk);
    chk("rsv_done", {30'd0, Done, Mem_CS}, 32'b10);
    @(negedge Clk);
    chk("rsv_idle", {30'd0, Busy, Cmd_Ready}, 32'b01);

    dv = '{8'h70, 8'h71, 8'h72, 8'h73, 8'h74, 8'h75, 8'h76, 8'h77};
    issue(2'b00, 6'd30, 6'd7, 8'h00);
    for (int i = 0; i < 2; i++) begin
      Wr_Data = dv[i]; Wr_Valid = 1; exp_mem[30 + i] = dv[i];
      @(posedge Clk); #1;
    end
    Wr_Data = dv[2];
    d0 = done_cnt;
    #1 chk("rst_pre_cs", {31'd0, Mem_CS}, 1);
    Rst = 1;
    #1 chk("rst_async_cs_wr", {30'd0, Mem_CS, Mem_WR}, 0);
    repeat (2) @(posedge Clk);
    #1 Rst = 0; Wr_Valid = 0;
    @(negedge Clk);
    chk("rst_release", {30'd0, Cmd_Ready, Busy}, 32'b10);
    chk("rst_no_done", done_cnt - d0, 0);
    for (int i = 30; i < 38; i++) chk("rst_ram_contents", {24'd0, ram[i]}, {24'd0, exp_mem[i]});
    read_burst(6'd30, 6'd7);

    repeat (3) @(negedge Clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
